// File: rtl/ahb_slave_if_param.sv
// AHB-side front end of the AHB-to-APB bridge: slot decode, stall-able pipeline, ERROR response FSM.
// Optional macro AHB_SLV_RDATA_REG_EN registers hrdata (one extra cycle of read latency).

module ahb_slv_pipe_stage #(
    parameter int W = 1
) (
    input  logic         hclk,
    input  logic         hreset,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge hclk) begin
        if (hreset)
            q <= '0;
        else if (en)
            q <= d;
    end
endmodule

module ahb_slave_if_param #(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter int                NUM_SEL     = 3,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h8000_0000,
    parameter logic [ADDR_W-1:0] REGION_SIZE = 32'h0400_0000,
    parameter int                PIPE_DEPTH  = 2
) (
    input  logic               hclk,
    input  logic               hreset,
    input  logic               hwrite,
    input  logic               hreadyin,
    input  logic [1:0]         htrans,
    input  logic [ADDR_W-1:0]  haddr,
    input  logic [DATA_W-1:0]  hwdata,
    input  logic [DATA_W-1:0]  prdata,
    input  logic               bridge_ready,
    output logic               valid,
    output logic [NUM_SEL-1:0] tempselx,
    output logic [ADDR_W-1:0]  haddr_s1,
    output logic [ADDR_W-1:0]  haddr_sn,
    output logic [DATA_W-1:0]  hwdata_s1,
    output logic [DATA_W-1:0]  hwdata_sn,
    output logic               hwrite_s1,
    output logic               hwrite_sn,
    output logic [DATA_W-1:0]  hrdata,
    output logic               hreadyout,
    output logic [1:0]         hresp
);
    localparam int SH = $clog2(REGION_SIZE);
    // Window bounds carry one extra bit so BASE_ADDR + span never wraps to 0.
    localparam logic [ADDR_W:0] WIN_LO = {1'b0, BASE_ADDR};
    localparam logic [ADDR_W:0] REG_X  = {1'b0, REGION_SIZE};
    localparam logic [ADDR_W:0] WIN_HI = WIN_LO + REG_X * (ADDR_W+1)'(NUM_SEL);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              wr;
    } stage_t;

    typedef enum logic [1:0] {OKAY, ERR1, ERR2} state_t;

    state_t                state, state_nx;
    stage_t [PIPE_DEPTH:0] stg;
    logic                  active, in_win, st_ok;
    logic [ADDR_W:0]       haddr_x;
    logic [ADDR_W-1:0]     offset, slot;
    logic                  unused_htrans0;

    assign unused_htrans0 = htrans[0];

    // ---------------- pipeline ----------------
    assign stg[0] = {haddr, hwdata, hwrite};

    genvar i;
    generate
        for (i = 1; i <= PIPE_DEPTH; i++) begin : g_pipe
            ahb_slv_pipe_stage #(.W($bits(stage_t))) u_stage (
                .hclk   (hclk),
                .hreset (hreset),
                .en     (hreadyin),
                .d      (stg[i-1]),
                .q      (stg[i])
            );
        end
    endgenerate

    assign haddr_s1  = stg[1].addr;
    assign hwdata_s1 = stg[1].data;
    assign hwrite_s1 = stg[1].wr;
    assign haddr_sn  = stg[PIPE_DEPTH].addr;
    assign hwdata_sn = stg[PIPE_DEPTH].data;
    assign hwrite_sn = stg[PIPE_DEPTH].wr;

    // ---------------- decode ----------------
    assign active  = hreadyin & htrans[1];
    assign haddr_x = {1'b0, haddr};
    assign in_win  = (haddr_x >= WIN_LO) && (haddr_x < WIN_HI);
    assign offset  = haddr - BASE_ADDR;
    assign slot    = offset >> SH;

    always_comb begin
        tempselx = '0;
        for (int s = 0; s < NUM_SEL; s++)
            tempselx[s] = in_win && (slot == ADDR_W'(s));
    end

    assign valid = active & in_win & st_ok;

    // ---------------- response FSM ----------------
    always_ff @(posedge hclk) begin
        if (hreset)
            state <= OKAY;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        hresp     = 2'b00;
        hreadyout = bridge_ready;
        st_ok     = 1'b1;
        case (state)
            OKAY: begin
                if (active && !in_win)
                    state_nx = ERR1;
            end
            ERR1: begin
                hresp     = 2'b01;
                hreadyout = 1'b0;
                st_ok     = 1'b0;
                state_nx  = ERR2;
            end
            ERR2: begin
                // Anything presented here is dropped; the master re-issues it.
                hresp     = 2'b01;
                hreadyout = 1'b1;
                st_ok     = 1'b0;
                state_nx  = OKAY;
            end
            default: begin
                state_nx = OKAY;
            end
        endcase
    end

    // ---------------- read data ----------------
`ifdef AHB_SLV_RDATA_REG_EN
    always_ff @(posedge hclk) begin
        if (hreset)
            hrdata <= '0;
        else if (bridge_ready)
            hrdata <= prdata;
    end
`else
    assign hrdata = prdata;
`endif

endmodule

// File: tb/tb_ahb_slave_if_param.sv
// Directed bench for ahb_slave_if_param at default parameters.
// Honours AHB_SLV_RDATA_REG_EN for the hrdata latency check.

module tb_ahb_slave_if_param;
    logic        hclk = 1'b0;
    logic        hreset, hwrite, hreadyin, bridge_ready;
    logic [1:0]  htrans;
    logic [31:0] haddr, hwdata, prdata;
    logic        valid, hwrite_s1, hwrite_sn, hreadyout;
    logic [2:0]  tempselx;
    logic [31:0] haddr_s1, haddr_sn, hwdata_s1, hwdata_sn, hrdata;
    logic [1:0]  hresp;

    int checks   = 0;
    int failures = 0;

    ahb_slave_if_param dut (
        .hclk(hclk), .hreset(hreset), .hwrite(hwrite), .hreadyin(hreadyin),
        .htrans(htrans), .haddr(haddr), .hwdata(hwdata), .prdata(prdata),
        .bridge_ready(bridge_ready), .valid(valid), .tempselx(tempselx),
        .haddr_s1(haddr_s1), .haddr_sn(haddr_sn), .hwdata_s1(hwdata_s1),
        .hwdata_sn(hwdata_sn), .hwrite_s1(hwrite_s1), .hwrite_sn(hwrite_sn),
        .hrdata(hrdata), .hreadyout(hreadyout), .hresp(hresp)
    );

    always #5 hclk = ~hclk;

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic set_idle();
        htrans = 2'b00; haddr = '0; hwdata = '0; hwrite = 1'b0;
    endtask

    task automatic test_reset();
        hreset = 1'b1; hreadyin = 1'b1; bridge_ready = 1'b1; prdata = '0;
        set_idle();
        tick(); tick();
        hreset = 1'b0;
        checks++; if (haddr_s1 !== 32'h0 || haddr_sn !== 32'h0) begin failures++; $display("FAIL reset_addr s1=%h sn=%h exp=0", haddr_s1, haddr_sn); end
        checks++; if (hwdata_s1 !== 32'h0 || hwdata_sn !== 32'h0) begin failures++; $display("FAIL reset_data s1=%h sn=%h exp=0", hwdata_s1, hwdata_sn); end
        checks++; if (hwrite_s1 !== 1'b0 || hwrite_sn !== 1'b0) begin failures++; $display("FAIL reset_wr s1=%b sn=%b exp=0", hwrite_s1, hwrite_sn); end
        checks++; if (hreadyout !== 1'b1 || hresp !== 2'b00) begin failures++; $display("FAIL reset_resp rdy=%b resp=%b exp=1/00", hreadyout, hresp); end
    endtask

    task automatic test_decode();
        htrans = 2'b10; haddr = 32'h8400_0010; hwdata = 32'h1234_5678; hwrite = 1'b1;
        #1;
        checks++; if (valid !== 1'b1) begin failures++; $display("FAIL decode_valid got=%b exp=1", valid); end
        checks++; if (tempselx !== 3'b010) begin failures++; $display("FAIL decode_sel got=%b exp=010", tempselx); end
        tick();
        checks++; if (haddr_s1 !== 32'h8400_0010 || haddr_sn !== 32'h0) begin failures++; $display("FAIL decode_edge1 s1=%h sn=%h exp=84000010/0", haddr_s1, haddr_sn); end
        set_idle();
        tick();
        checks++; if (haddr_sn !== 32'h8400_0010) begin failures++; $display("FAIL decode_sn_addr got=%h exp=84000010", haddr_sn); end
        checks++; if (hwdata_sn !== 32'h1234_5678 || hwrite_sn !== 1'b1) begin failures++; $display("FAIL decode_sn_data got=%h/%b exp=12345678/1", hwdata_sn, hwrite_sn); end
        checks++; if (haddr_s1 !== 32'h0) begin failures++; $display("FAIL decode_s1_next got=%h exp=0", haddr_s1); end
    endtask

    task automatic test_boundaries();
        logic [31:0] ta [6];
        logic [2:0]  ts [6];
        ta[0] = 32'h8000_0000; ts[0] = 3'b001;
        ta[1] = 32'h83FF_FFFF; ts[1] = 3'b001;
        ta[2] = 32'h8400_0000; ts[2] = 3'b010;
        ta[3] = 32'h8BFF_FFFC; ts[3] = 3'b100;
        ta[4] = 32'h8C00_0000; ts[4] = 3'b000;
        ta[5] = 32'h7FFF_FFFC; ts[5] = 3'b000;
        htrans = 2'b10;
        for (int k = 0; k < 6; k++) begin
            haddr = ta[k];
            #1;
            checks++; if (tempselx !== ts[k] || valid !== (ts[k] != 3'b000)) begin failures++; $display("FAIL bound_%0d addr=%h sel=%b valid=%b exp_sel=%b", k, ta[k], tempselx, valid, ts[k]); end
        end
        set_idle();
    endtask

    task automatic test_error();
        htrans = 2'b10; haddr = 32'h8C00_0000;
        #1;
        checks++; if (valid !== 1'b0 || hresp !== 2'b00) begin failures++; $display("FAIL err_detect valid=%b resp=%b exp=0/00", valid, hresp); end
        tick();
        haddr = 32'h8000_0000;   // in-window transfer must still be suppressed
        #1;
        checks++; if (hresp !== 2'b01 || hreadyout !== 1'b0 || valid !== 1'b0) begin failures++; $display("FAIL err1 resp=%b rdy=%b valid=%b exp=01/0/0", hresp, hreadyout, valid); end
        tick();
        haddr = 32'hC000_0000;   // out-of-window in ERR2 is ignored
        #1;
        checks++; if (hresp !== 2'b01 || hreadyout !== 1'b1 || valid !== 1'b0) begin failures++; $display("FAIL err2 resp=%b rdy=%b valid=%b exp=01/1/0", hresp, hreadyout, valid); end
        tick();
        set_idle();
        #1;
        checks++; if (hresp !== 2'b00 || hreadyout !== 1'b1) begin failures++; $display("FAIL err_back_okay resp=%b rdy=%b exp=00/1", hresp, hreadyout); end
        tick();
        checks++; if (hresp !== 2'b00) begin failures++; $display("FAIL err2_ignored resp=%b exp=00", hresp); end
    endtask

    task automatic test_back_to_back_stall();
        htrans = 2'b10; haddr = 32'h8000_0100; hwdata = 32'h11; hwrite = 1'b1;
        tick();
        htrans = 2'b11; haddr = 32'h8000_0104; hwdata = 32'h22; hwrite = 1'b0;
        tick();
        hreadyin = 1'b0; haddr = 32'h8000_0108; hwdata = 32'h33; hwrite = 1'b1;
        #1;
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL stall_valid got=%b exp=0", valid); end
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++; if (haddr_s1 !== 32'h8000_0104 || haddr_sn !== 32'h8000_0100 || hwdata_sn !== 32'h11 || hwrite_s1 !== 1'b0) begin failures++; $display("FAIL stall_hold_%0d s1=%h sn=%h dsn=%h w1=%b", c, haddr_s1, haddr_sn, hwdata_sn, hwrite_s1); end
        end
        checks++; if (hresp !== 2'b00) begin failures++; $display("FAIL stall_resp got=%b exp=00", hresp); end
        hreadyin = 1'b1;
        tick();
        checks++; if (haddr_s1 !== 32'h8000_0108 || haddr_sn !== 32'h8000_0104 || hwdata_sn !== 32'h22 || hwrite_sn !== 1'b0) begin failures++; $display("FAIL stall_resume s1=%h sn=%h dsn=%h wsn=%b", haddr_s1, haddr_sn, hwdata_sn, hwrite_sn); end
        set_idle();
    endtask

    task automatic test_idle_busy();
        logic [1:0] tt [2];
        tt[0] = 2'b00; tt[1] = 2'b01;
        for (int k = 0; k < 2; k++) begin
            htrans = tt[k]; haddr = 32'h0;
            #1;
            checks++; if (valid !== 1'b0 || hresp !== 2'b00) begin failures++; $display("FAIL idle_%0d valid=%b resp=%b exp=0/00", k, valid, hresp); end
            tick();
            checks++; if (hresp !== 2'b00 || hreadyout !== 1'b1) begin failures++; $display("FAIL idle_next_%0d resp=%b rdy=%b exp=00/1", k, hresp, hreadyout); end
        end
        set_idle();
    endtask

    task automatic test_hrdata();
        prdata = 32'hDEAD_BEEF; bridge_ready = 1'b1;
        #1;
`ifdef AHB_SLV_RDATA_REG_EN
        checks++; if (hrdata !== 32'h0) begin failures++; $display("FAIL rdata_pre got=%h exp=0", hrdata); end
        tick();
        checks++; if (hrdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL rdata_load got=%h exp=deadbeef", hrdata); end
        bridge_ready = 1'b0; prdata = 32'h1234_5678;
        tick();
        checks++; if (hrdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL rdata_hold got=%h exp=deadbeef", hrdata); end
`else
        checks++; if (hrdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL rdata_comb got=%h exp=deadbeef", hrdata); end
        bridge_ready = 1'b0; prdata = 32'h1234_5678;
        #1;
        checks++; if (hrdata !== 32'h1234_5678) begin failures++; $display("FAIL rdata_comb2 got=%h exp=12345678", hrdata); end
`endif
        checks++; if (hreadyout !== 1'b0) begin failures++; $display("FAIL okay_bridge_busy rdy=%b exp=0", hreadyout); end
        bridge_ready = 1'b1;
        tick();
    endtask

    task automatic test_reset_in_err();
        htrans = 2'b10; haddr = 32'h8C00_0000;
        tick();
        checks++; if (hresp !== 2'b01) begin failures++; $display("FAIL rst_err_enter resp=%b exp=01", hresp); end
        hreset = 1'b1;
        set_idle();
        tick();
        checks++; if (hresp !== 2'b00 || hreadyout !== 1'b1 || haddr_s1 !== 32'h0) begin failures++; $display("FAIL rst_err_abort resp=%b rdy=%b s1=%h exp=00/1/0", hresp, hreadyout, haddr_s1); end
        hreset = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_decode();
        test_boundaries();
        test_error();
        test_back_to_back_stall();
        test_idle_busy();
        test_hrdata();
        test_reset_in_err();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
